prng_operand_dispatch: RTL
==========================

# prng_operand_dispatch

Sits directly downstream of the pseudo-random number generator and turns its unthrottled 49-bit word stream into flow-controlled operand packets for the systolic array. Each accepted word is buffered in a small show-ahead FIFO, which absorbs stalls because the generator cannot be back-pressured. The word is then split into func/x/y/z fields and issued over a valid/ready handshake. The block counts issued packets, flags dropped words, and raises a completion pulse once the generator's done has been seen and the buffer has drained.

## Interface
- DATA_WIDTH, 49, generator word width; must equal 1 + 3*OP_WIDTH
- OP_WIDTH, 16, width of each x/y/z operand
- FIFO_DEPTH, 4, buffer entries; power of two, ≥ 2
- CNT_WIDTH, 16, width of issued-packet counter
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_clr  in  1  synchronous clear: flush FIFO, zero counter/overflow/signature, state to IDLE
- i_vld  in  1  generator word valid
- i_data  in  DATA_WIDTH  generator word
- i_done  in  1  generator done pulse
- i_rdy  in  1  downstream ready
- o_vld  out  1  packet valid (FIFO non-empty)
- o_func  out  1  i_data[DATA_WIDTH-1] of head word
- o_x / o_y / o_z  out  OP_WIDTH each  head word [47:32] / [31:16] / [15:0] (for defaults)
- o_count  out  CNT_WIDTH  packets issued, saturating
- o_overflow  out  1  sticky: a word was dropped
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_signature  out  DATA_WIDTH  MISR signature (only with PRNG_DISPATCH_MISR_EN)

## Operation
- Write: i_vld=1 pushes i_data. If the FIFO is full and no pop occurs that cycle, the word is dropped and o_overflow is set. If full with a simultaneous pop, the write is accepted.
- Pop: o_vld && i_rdy. o_count increments per pop and holds at 2^CNT_WIDTH-1.
- Fields are combinational slices of the FIFO head. Outputs are stable while o_vld=1 and i_rdy=0.
- FSM states:
  - IDLE: FIFO empty, no done pending.
  - ACTIVE: entered from IDLE on i_vld.
  - DRAIN: entered on i_done (registered done-pending).
  - DONE: entered from DRAIN when the FIFO is empty and no write is in progress. o_done=1 in DONE. DONE → IDLE next cycle.
- i_done in IDLE with an empty FIFO goes straight to DONE.
- i_done with i_vld in the same cycle: the word is written first, so that word is issued before o_done.
- i_vld during DRAIN: the word is still accepted and drained (not expected from the generator).
- i_clr has priority over push, pop and i_done in the same cycle.
- Reset values: o_vld=0, o_count=0, o_overflow=0, o_busy=0, o_done=0, o_signature=0, FIFO pointers 0, state IDLE. Field outputs are don't-care while o_vld=0.

## Timing
- Latency: i_vld at cycle N → o_vld at N+1 when the FIFO was empty.
- Throughput: one packet per cycle with i_rdy held high.
- o_done asserts one cycle after the pop that empties the FIFO, given done is pending. If i_done arrives with an empty FIFO, o_done asserts at N+1.
- i_clr and pointer/count updates take effect at the next edge. Asynchronous i_rst mid-stream discards all contents immediately.
- Pointer wrap: pointers carry one extra bit. Full = MSBs differ and low bits equal.

## Configuration
- PRNG_DISPATCH_MISR_EN defined:
  - o_signature is present.
  - On each pop: sig ← rotl1(sig) ^ popped word.
  - Cleared by reset and by i_clr.
- PRNG_DISPATCH_MISR_EN undefined: the port and its logic are absent.

## Structure
- Package prng_dispatch_pkg holds:
  - enum st_dispatch_state {IDLE, ACTIVE, DRAIN, DONE}
  - localparams FUNC_BIT, X_LSB, Y_LSB, Z_LSB derived from OP_WIDTH
- One sub-module, prng_dispatch_fifo: show-ahead FIFO with push/pop/full/empty/flush. The FSM, counter, overflow flag and MISR live in the top module.

## Test plan
- Single word: push 49'h1_0001_0002_0003, i_rdy=1 → o_vld at N+1 with func=1, x=1, y=2, z=3; o_count=1.
- Backpressure: i_rdy=0, push 5 words at FIFO_DEPTH=4 → first 4 retained, o_overflow=1. Release i_rdy → exactly 4 packets in order.
- Full plus simultaneous pop: FIFO full, i_rdy=1, i_vld=1 → no drop; o_overflow stays 0.
- Done drain: 3 words then i_done, i_rdy=1 → o_done pulses once, exactly one cycle after the 3rd pop; o_busy falls the cycle after.
- i_clr mid-stream with 2 words buffered → o_vld=0, o_count=0, o_overflow=0 next cycle; a later i_done yields o_done at N+1.
- MISR (macro on): pop 49'h1 then 49'h2 → o_signature 49'h1, then 49'h0.

Source files
------------

// File: rtl/prng_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prng_dispatch_pkg
// Purpose  : Shared types and field-layout constants for the PRNG operand
//            dispatcher (state encoding, operand field positions).
// Revision : 1.0 - initial release
// ============================================================================
package prng_dispatch_pkg;

   // Operand width the default field layout is derived from
   localparam int unsigned DEF_OP_WIDTH = 16;

   // LSB of operand slot 'slot' (0 = z, 1 = y, 2 = x, 3 = func bit)
   function automatic int unsigned op_lsb(input int unsigned op_w, input int unsigned slot);
      return slot * op_w;
   endfunction

   localparam int unsigned FUNC_BIT = op_lsb(DEF_OP_WIDTH, 3);
   localparam int unsigned X_LSB    = op_lsb(DEF_OP_WIDTH, 2);
   localparam int unsigned Y_LSB    = op_lsb(DEF_OP_WIDTH, 1);
   localparam int unsigned Z_LSB    = op_lsb(DEF_OP_WIDTH, 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } st_dispatch_state;

endpackage
`default_nettype wire

// File: rtl/prng_operand_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : prng_operand_dispatch_if
// Purpose  : Generator-side and array-side signals of the operand dispatcher.
//            o_signature exists only when PRNG_DISPATCH_MISR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface prng_operand_dispatch_if #(
   parameter int DATA_WIDTH = 49,
   parameter int OP_WIDTH   = 16,
   parameter int CNT_WIDTH  = 16
);
   logic                  i_clr;
   logic                  i_vld;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_done;
   logic                  i_rdy;
   logic                  o_vld;
   logic                  o_func;
   logic [OP_WIDTH-1:0]   o_x;
   logic [OP_WIDTH-1:0]   o_y;
   logic [OP_WIDTH-1:0]   o_z;
   logic [CNT_WIDTH-1:0]  o_count;
   logic                  o_overflow;
   logic                  o_busy;
   logic                  o_done;
`ifdef PRNG_DISPATCH_MISR_EN
   logic [DATA_WIDTH-1:0] o_signature;
`endif

   // Driver side: generator, downstream ready and control
   modport master (
      output i_clr, i_vld, i_data, i_done, i_rdy,
      input  o_vld, o_func, o_x, o_y, o_z, o_count, o_overflow, o_busy, o_done
`ifdef PRNG_DISPATCH_MISR_EN
      , input o_signature
`endif
   );

   // Dispatcher side
   modport slave (
      input  i_clr, i_vld, i_data, i_done, i_rdy,
      output o_vld, o_func, o_x, o_y, o_z, o_count, o_overflow, o_busy, o_done
`ifdef PRNG_DISPATCH_MISR_EN
      , output o_signature
`endif
   );

endinterface
`default_nettype wire

// File: rtl/prng_dispatch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prng_dispatch_fifo
// Purpose  : Show-ahead FIFO; head word is visible combinationally while
//            non-empty. Pointers carry one wrap bit to tell full from empty.
// Revision : 1.0 - initial release
// ============================================================================
module prng_dispatch_fifo #(
   parameter int DATA_WIDTH = 49,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic                          i_clk,
   input  wire logic                          i_rst,
   input  wire logic                          i_flush,
   input  wire logic                          i_push,
   input  wire logic [DATA_WIDTH-1:0]         i_data,
   input  wire logic                          i_pop,
   output logic      [DATA_WIDTH-1:0]         o_head,
   output logic                               o_full,
   output logic                               o_empty,
   output logic      [$clog2(FIFO_DEPTH):0]   o_level
);
   localparam int C_AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [C_AW:0]         r_wr_ptr;
   logic [C_AW:0]         r_rd_ptr;
   logic                  w_push;
   logic                  w_pop;

   // Flush dominates; a pop of an empty FIFO is ignored
   assign w_push = i_push && !i_flush;
   assign w_pop  = i_pop  && !i_flush && !o_empty;

   // Pointer update; async reset discards contents at once
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage array, written at the write pointer
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[C_AW-1:0]] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr[C_AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                    (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
   assign o_level = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/prng_operand_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : prng_operand_dispatch
// Purpose  : Buffers the PRNG word stream, splits each word into func/x/y/z
//            and issues it over valid/ready; counts packets, flags drops and
//            pulses o_done once generator done is seen and the buffer drains.
//            Optional MISR signature: define PRNG_DISPATCH_MISR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prng_operand_dispatch
   import prng_dispatch_pkg::*;
#(
   parameter int DATA_WIDTH = 49,
   parameter int OP_WIDTH   = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input wire logic                 i_clk,
   input wire logic                 i_rst,
   prng_operand_dispatch_if.slave   bus
);
   localparam int C_AW       = $clog2(FIFO_DEPTH);
   localparam int C_FUNC_BIT = int'(op_lsb(OP_WIDTH, 3));
   localparam int C_X_LSB    = int'(op_lsb(OP_WIDTH, 2));
   localparam int C_Y_LSB    = int'(op_lsb(OP_WIDTH, 1));
   localparam int C_Z_LSB    = int'(op_lsb(OP_WIDTH, 0));
   localparam logic [C_AW:0]      C_LEVEL_ONE = {{C_AW{1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

   st_dispatch_state       r_state;
   st_dispatch_state       w_state_nxt;
   logic [DATA_WIDTH-1:0]  w_head;
   logic                   w_full;
   logic                   w_empty;
   logic [C_AW:0]          w_level;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_will_empty;
   logic                   w_done_pend;
   logic                   w_busy;
   logic                   w_done;
   logic [CNT_WIDTH-1:0]   r_count;
   logic                   r_overflow;

   // A full FIFO still accepts a write when the head leaves the same cycle
   assign w_pop  = !w_empty && bus.i_rdy;
   assign w_push = bus.i_vld && (!w_full || w_pop);
   assign w_drop = bus.i_vld && w_full && !w_pop;

   // FIFO will hold nothing after this edge
   assign w_will_empty = (w_empty && !w_push) ||
                         ((w_level == C_LEVEL_ONE) && w_pop && !w_push);
   assign w_done_pend  = (r_state == DRAIN) || bus.i_done;

   prng_dispatch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (bus.i_clr),
      .i_push  (w_push),
      .i_data  (bus.i_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state: pending done completes as soon as the buffer will be empty
   always_comb begin
      w_state_nxt = r_state;
      if (bus.i_clr) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE, ACTIVE, DRAIN: begin
               if (w_done_pend && w_will_empty)  w_state_nxt = DONE;
               else if (w_done_pend)             w_state_nxt = DRAIN;
               else if ((r_state == IDLE) && bus.i_vld) w_state_nxt = ACTIVE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // State-decoded outputs
   always_comb begin
      w_busy = (r_state != IDLE);
      w_done = (r_state == DONE);
   end

   // Saturating issued-packet counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                            r_count <= '0;
      else if (bus.i_clr)                   r_count <= '0;
      else if (w_pop && r_count != C_CNT_MAX) r_count <= r_count + 1'b1;
   end

   // Sticky drop flag
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)          r_overflow <= 1'b0;
      else if (bus.i_clr) r_overflow <= 1'b0;
      else if (w_drop)    r_overflow <= 1'b1;
   end

`ifdef PRNG_DISPATCH_MISR_EN
   logic [DATA_WIDTH-1:0] r_signature;

   // MISR: rotate left by one and fold in each popped word
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)          r_signature <= '0;
      else if (bus.i_clr) r_signature <= '0;
      else if (w_pop)     r_signature <= {r_signature[DATA_WIDTH-2:0], r_signature[DATA_WIDTH-1]} ^ w_head;
   end

   assign bus.o_signature = r_signature;
`endif

   assign bus.o_vld      = !w_empty;
   assign bus.o_func     = w_head[C_FUNC_BIT];
   assign bus.o_x        = w_head[C_X_LSB +: OP_WIDTH];
   assign bus.o_y        = w_head[C_Y_LSB +: OP_WIDTH];
   assign bus.o_z        = w_head[C_Z_LSB +: OP_WIDTH];
   assign bus.o_count    = r_count;
   assign bus.o_overflow = r_overflow;
   assign bus.o_busy     = w_busy;
   assign bus.o_done     = w_done;

endmodule
`default_nettype wire
